// File: rtl/pid_regbank.sv
// -----------------------------------------------------------------------------
// pid_regbank
//
// Byte-addressed register bank for up to eight PID channels. Each channel has
// four coefficient/setpoint words (P, I, D, SP), a control register
// (bit0 COMMIT, write-only; bit1 ENABLE) and two read-only live status words
// (PID_O, PWM_O). The read-only words are captured into a per-channel snapshot
// when lane 0 is read, so a multi-byte read sees one consistent value.
//
// Byte address layout (w_addr and r_addr):
//   [7:5] channel, [4:2] register index, [1:0] byte lane
//   index 0 P, 1 I, 2 D, 3 SP, 4 CTRL, 5 reserved, 6 PID_O, 7 PWM_O
//
// Optional feature, selected by the macro PID_REGBANK_SHADOW_EN:
//   defined   - writes to P/I/D/SP land in shadow registers and reads return the
//               shadow; a CTRL write with bit0=1 copies all four shadows of
//               that channel to the active outputs on the same edge.
//   undefined - no shadow storage; writes go straight to the active outputs
//               and COMMIT has no effect.
//
// Ports:
//   clk_in        single clock, all state on its rising edge
//   reset         asynchronous, active-high reset
//   write_enable  byte write strobe, with w_addr / w_data
//   read_enable   byte read strobe, with r_addr
//   r_data_o      registered read byte, valid when r_valid_o is high
//   r_valid_o     one-cycle pulse, one cycle after read_enable
//   p, i, d, sp   active words, channel n at [n*DATA_W +: DATA_W]
//   ch_en_o       per-channel CTRL.ENABLE
//   pid_o_i       live PID output status per channel (read-only register)
//   pwm_o_i       live PWM status per channel (read-only register)
// -----------------------------------------------------------------------------
module pid_regbank #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     write_enable,
    input  logic [7:0]               w_addr,
    input  logic [7:0]               w_data,
    input  logic                     read_enable,
    input  logic [7:0]               r_addr,
    output logic [7:0]               r_data_o,
    output logic                     r_valid_o,
    output logic [NUM_CH*DATA_W-1:0] p,
    output logic [NUM_CH*DATA_W-1:0] i,
    output logic [NUM_CH*DATA_W-1:0] d,
    output logic [NUM_CH*DATA_W-1:0] sp,
    output logic [NUM_CH-1:0]        ch_en_o,
    input  logic [NUM_CH*DATA_W-1:0] pid_o_i,
    input  logic [NUM_CH*DATA_W-1:0] pwm_o_i
);

    localparam int         LANES    = DATA_W / 8;
    localparam logic [2:0] LANES_L  = 3'(LANES);
    localparam logic [2:0] IDX_CTRL = 3'd4;
    localparam logic [2:0] IDX_PID  = 3'd6;
    localparam logic [2:0] IDX_PWM  = 3'd7;

    // Elaboration-time parameter guard.
    if ((DATA_W != 16) && (DATA_W != 24) && (DATA_W != 32)) begin : g_bad_data_w
        $error("pid_regbank: DATA_W must be 16, 24 or 32");
    end
    if ((NUM_CH < 1) || (NUM_CH > 8)) begin : g_bad_num_ch
        $error("pid_regbank: NUM_CH must be in 1..8");
    end

    // -------------------------------------------------------------------------
    // Address decode shared by all channels
    // -------------------------------------------------------------------------
    logic [2:0] wr_ch;
    logic [2:0] wr_idx;
    logic [1:0] wr_lane;
    logic [2:0] rd_ch;
    logic [2:0] rd_idx;
    logic [1:0] rd_lane;
    logic       wr_lane_ok;
    logic       rd_lane_ok;
    logic       wr_coef;
    logic       wr_ctrl;

    assign wr_ch   = w_addr[7:5];
    assign wr_idx  = w_addr[4:2];
    assign wr_lane = w_addr[1:0];
    assign rd_ch   = r_addr[7:5];
    assign rd_idx  = r_addr[4:2];
    assign rd_lane = r_addr[1:0];

    assign wr_lane_ok = ({1'b0, wr_lane} < LANES_L);
    assign rd_lane_ok = ({1'b0, rd_lane} < LANES_L);

    // Coefficient write: indices 0..3 and a lane that exists at this width.
    assign wr_coef = write_enable && !wr_idx[2] && wr_lane_ok;
    // CTRL is a single byte; lanes 1..3 are ignored.
    assign wr_ctrl = write_enable && (wr_idx == IDX_CTRL) && (wr_lane == 2'd0);

    // Per-channel read byte, selected by rd_ch below. Channels that do not
    // exist never match the selector and therefore read as zero.
    logic [NUM_CH*8-1:0] rd_bus;

    // -------------------------------------------------------------------------
    // Per-channel storage
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [2:0] CH = 3'(gi);

        logic [DATA_W-1:0] act_q  [4];
        logic [DATA_W-1:0] snap_q [2];
        logic              en_q;
        logic              coef_hit;
        logic              ctrl_hit;
        logic              snap_pid_hit;
        logic              snap_pwm_hit;
        logic [DATA_W-1:0] live_pid;
        logic [DATA_W-1:0] live_pwm;
        logic [DATA_W-1:0] rd_word;

        assign coef_hit = wr_coef && (wr_ch == CH);
        assign ctrl_hit = wr_ctrl && (wr_ch == CH);
        assign live_pid = pid_o_i[gi*DATA_W +: DATA_W];
        assign live_pwm = pwm_o_i[gi*DATA_W +: DATA_W];

        // A lane-0 read of a status word captures the whole live word.
        assign snap_pid_hit = read_enable && (rd_ch == CH) &&
                              (rd_idx == IDX_PID) && (rd_lane == 2'd0);
        assign snap_pwm_hit = read_enable && (rd_ch == CH) &&
                              (rd_idx == IDX_PWM) && (rd_lane == 2'd0);

`ifdef PID_REGBANK_SHADOW_EN
        logic [DATA_W-1:0] shd_q [4];

        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                for (int r = 0; r < 4; r++) begin
                    shd_q[r] <= '0;
                end
            end else if (coef_hit) begin
                shd_q[wr_idx[1:0]][{wr_lane, 3'b000} +: 8] <= w_data;
            end
        end

        // COMMIT moves all four shadows at once so the loop never sees a
        // mix of old and new coefficients.
        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                for (int r = 0; r < 4; r++) begin
                    act_q[r] <= '0;
                end
            end else if (ctrl_hit && w_data[0]) begin
                for (int r = 0; r < 4; r++) begin
                    act_q[r] <= shd_q[r];
                end
            end
        end
`else
        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                for (int r = 0; r < 4; r++) begin
                    act_q[r] <= '0;
                end
            end else if (coef_hit) begin
                act_q[wr_idx[1:0]][{wr_lane, 3'b000} +: 8] <= w_data;
            end
        end
`endif

        // ENABLE follows the CTRL write directly, regardless of COMMIT.
        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                en_q <= 1'b0;
            end else if (ctrl_hit) begin
                en_q <= w_data[1];
            end
        end

        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                snap_q[0] <= '0;
                snap_q[1] <= '0;
            end else begin
                if (snap_pid_hit) begin
                    snap_q[0] <= live_pid;
                end
                if (snap_pwm_hit) begin
                    snap_q[1] <= live_pwm;
                end
            end
        end

        // Read word for this channel, taken from current (pre-write) state so
        // a same-cycle write to the same byte returns the old value.
        always_comb begin
            rd_word = '0;
            case (rd_idx)
`ifdef PID_REGBANK_SHADOW_EN
                3'd0, 3'd1, 3'd2, 3'd3: rd_word = shd_q[rd_idx[1:0]];
`else
                3'd0, 3'd1, 3'd2, 3'd3: rd_word = act_q[rd_idx[1:0]];
`endif
                // COMMIT is write-only, so bit0 always reads back as 0.
                IDX_CTRL: rd_word = DATA_W'({en_q, 1'b0});
                IDX_PID:  rd_word = (rd_lane == 2'd0) ? live_pid : snap_q[0];
                IDX_PWM:  rd_word = (rd_lane == 2'd0) ? live_pwm : snap_q[1];
                default:  rd_word = '0;
            endcase
        end

        assign rd_bus[gi*8 +: 8] = rd_lane_ok ? 8'(rd_word >> {rd_lane, 3'b000})
                                              : 8'h00;

        assign p[gi*DATA_W +: DATA_W]  = act_q[0];
        assign i[gi*DATA_W +: DATA_W]  = act_q[1];
        assign d[gi*DATA_W +: DATA_W]  = act_q[2];
        assign sp[gi*DATA_W +: DATA_W] = act_q[3];
        assign ch_en_o[gi]             = en_q;
    end

    // -------------------------------------------------------------------------
    // Read channel select and output register
    // -------------------------------------------------------------------------
    logic [7:0] r_data_d;
    logic [7:0] r_data_q;
    logic       r_valid_q;

    always_comb begin
        r_data_d = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == 3'(c)) begin
                r_data_d = rd_bus[c*8 +: 8];
            end
        end
    end

    // Reset clears r_valid_q immediately, which also drops any read that was
    // issued in the cycle reset arrives.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_data_q  <= 8'h00;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= read_enable;
            if (read_enable) begin
                r_data_q <= r_data_d;
            end
        end
    end

    assign r_data_o  = r_data_q;
    assign r_valid_o = r_valid_q;

endmodule

// File: tb/tb_pid_regbank.sv
// -----------------------------------------------------------------------------
// tb_pid_regbank
//
// Directed bench for pid_regbank at DATA_W=16, NUM_CH=4. Every expected value
// below is written out by hand from the register map.
// -----------------------------------------------------------------------------
module tb_pid_regbank;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 4;
    localparam int BUS_W  = NUM_CH * DATA_W;

    logic             clk_in;
    logic             reset;
    logic             write_enable;
    logic [7:0]       w_addr;
    logic [7:0]       w_data;
    logic             read_enable;
    logic [7:0]       r_addr;
    logic [7:0]       r_data_o;
    logic             r_valid_o;
    logic [BUS_W-1:0] p;
    logic [BUS_W-1:0] i;
    logic [BUS_W-1:0] d;
    logic [BUS_W-1:0] sp;
    logic [NUM_CH-1:0] ch_en_o;
    logic [BUS_W-1:0] pid_o_i;
    logic [BUS_W-1:0] pwm_o_i;

    int errors = 0;
    int checks = 0;

    pid_regbank #(
        .DATA_W(DATA_W),
        .NUM_CH(NUM_CH)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .write_enable(write_enable),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .read_enable (read_enable),
        .r_addr      (r_addr),
        .r_data_o    (r_data_o),
        .r_valid_o   (r_valid_o),
        .p           (p),
        .i           (i),
        .d           (d),
        .sp          (sp),
        .ch_en_o     (ch_en_o),
        .pid_o_i     (pid_o_i),
        .pwm_o_i     (pwm_o_i)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One byte write; returns on the falling edge after the write edge.
    task automatic wr(input logic [2:0] ch, input logic [2:0] idx,
                      input logic [1:0] lane, input logic [7:0] data);
        @(negedge clk_in);
        write_enable = 1'b1;
        w_addr       = {ch, idx, lane};
        w_data       = data;
        @(negedge clk_in);
        write_enable = 1'b0;
        $display("WR ch=%0d idx=%0d lane=%0d data=0x%02h", ch, idx, lane, data);
    endtask

    // One byte read; samples r_data_o / r_valid_o on the falling edge after
    // the registering edge.
    task automatic rd(input string tag, input logic [2:0] ch, input logic [2:0] idx,
                      input logic [1:0] lane, input logic [7:0] exp);
        @(negedge clk_in);
        read_enable = 1'b1;
        r_addr      = {ch, idx, lane};
        @(negedge clk_in);
        read_enable = 1'b0;
        $display("RD ch=%0d idx=%0d lane=%0d data=0x%02h valid=%0b",
                 ch, idx, lane, r_data_o, r_valid_o);
        check({tag, "_valid"}, 64'(r_valid_o), 64'd1);
        check({tag, "_data"}, 64'(r_data_o), 64'(exp));
    endtask

    initial begin
        reset        = 1'b1;
        write_enable = 1'b0;
        w_addr       = 8'h00;
        w_data       = 8'h00;
        read_enable  = 1'b0;
        r_addr       = 8'h00;
        pid_o_i      = '0;
        pwm_o_i      = '0;

        // ---- reset state ----
        #1;
        check("rst_p", 64'(p), 64'd0);
        check("rst_sp", 64'(sp), 64'd0);
        check("rst_en", 64'(ch_en_o), 64'd0);
        check("rst_rvalid", 64'(r_valid_o), 64'd0);
        check("rst_rdata", 64'(r_data_o), 64'd0);
        repeat (2) @(negedge clk_in);
        reset = 1'b0;

        // ---- ch0 P = 0x1234 byte by byte ----
        wr(3'd0, 3'd0, 2'd0, 8'h34);
`ifndef PID_REGBANK_SHADOW_EN
        check("p_lane0", 64'(p[15:0]), 64'h0034);
`endif
        wr(3'd0, 3'd0, 2'd1, 8'h12);
`ifdef PID_REGBANK_SHADOW_EN
        wr(3'd0, 3'd4, 2'd0, 8'h01);
`endif
        check("p_full", 64'(p[15:0]), 64'h1234);
        rd("p_rd_l1", 3'd0, 3'd0, 2'd1, 8'h12);
        @(negedge clk_in);
        check("rvalid_drop", 64'(r_valid_o), 64'd0);

        // ---- ch2 SP and CTRL ----
        wr(3'd2, 3'd3, 2'd0, 8'hAB);
`ifdef PID_REGBANK_SHADOW_EN
        check("sp_before_commit", 64'(sp[47:32]), 64'h0000);
        rd("sp_shadow_rd", 3'd2, 3'd3, 2'd0, 8'hAB);
`else
        check("sp_direct", 64'(sp[47:32]), 64'h00AB);
`endif
        wr(3'd2, 3'd4, 2'd0, 8'h03);
        check("sp_after_ctrl", 64'(sp[47:32]), 64'h00AB);
        check("en_ch2", 64'(ch_en_o), 64'h4);
        check("p_untouched", 64'(p), 64'h1234);
        rd("ctrl_rd", 3'd2, 3'd4, 2'd0, 8'h02);

        // ---- RO snapshots on ch1 ----
        pid_o_i[31:16] = 16'h1111;
        rd("pid_l0", 3'd1, 3'd6, 2'd0, 8'h11);
        pid_o_i[31:16] = 16'h2222;
        rd("pid_l1_snap", 3'd1, 3'd6, 2'd1, 8'h11);
        rd("pid_l0_new", 3'd1, 3'd6, 2'd0, 8'h22);
        pwm_o_i[31:16] = 16'hBEEF;
        rd("pwm_l1_presnap", 3'd1, 3'd7, 2'd1, 8'h00);
        rd("pwm_l0", 3'd1, 3'd7, 2'd0, 8'hEF);
        rd("pwm_l1", 3'd1, 3'd7, 2'd1, 8'hBE);

        // ---- ignored writes / zero reads ----
        wr(3'd5, 3'd0, 2'd0, 8'hFF);
        check("ch5_wr_p", 64'(p), 64'h1234);
        wr(3'd0, 3'd0, 2'd2, 8'hFF);
        check("lane2_wr_p", 64'(p), 64'h1234);
        wr(3'd0, 3'd7, 2'd0, 8'h77);
        wr(3'd0, 3'd5, 2'd0, 8'h66);
        wr(3'd0, 3'd4, 2'd1, 8'h02);
        check("ign_p", 64'(p), 64'h1234);
        check("ign_i", 64'(i), 64'h0);
        check("ign_d", 64'(d), 64'h0);
        check("ign_sp", 64'(sp), 64'h0000_00AB_0000_0000);
        check("ign_en", 64'(ch_en_o), 64'h4);
        rd("ch5_rd", 3'd5, 3'd0, 2'd0, 8'h00);
        rd("lane2_rd", 3'd0, 3'd0, 2'd2, 8'h00);
        rd("pwm0_rd", 3'd0, 3'd7, 2'd0, 8'h00);
        rd("rsvd_rd", 3'd0, 3'd5, 2'd0, 8'h00);
        rd("ctrl_l1_rd", 3'd2, 3'd4, 2'd1, 8'h00);

        // ---- same-cycle read and write of ch0 I lane 0 ----
        wr(3'd0, 3'd1, 2'd0, 8'h55);
        @(negedge clk_in);
        write_enable = 1'b1;
        w_addr       = {3'd0, 3'd1, 2'd0};
        w_data       = 8'hAA;
        read_enable  = 1'b1;
        r_addr       = {3'd0, 3'd1, 2'd0};
        @(negedge clk_in);
        write_enable = 1'b0;
        read_enable  = 1'b0;
        $display("RW ch=0 idx=1 lane=0 wdata=0xaa rdata=0x%02h valid=%0b", r_data_o, r_valid_o);
        check("rw_valid", 64'(r_valid_o), 64'd1);
        check("rw_old", 64'(r_data_o), 64'h55);
`ifndef PID_REGBANK_SHADOW_EN
        check("rw_i_out", 64'(i[15:0]), 64'h00AA);
`endif
        rd("rw_new", 3'd0, 3'd1, 2'd0, 8'hAA);

        // ---- asynchronous reset mid-sequence ----
        @(negedge clk_in);
        read_enable = 1'b1;
        r_addr      = {3'd0, 3'd0, 2'd0};
        @(posedge clk_in);
        #2;
        check("pre_rst_rvalid", 64'(r_valid_o), 64'd1);
        check("pre_rst_p", 64'(p), 64'h1234);
        reset = 1'b1;
        #1;
        $display("RST async asserted p=0x%0h en=0x%0h rvalid=%0b", p, ch_en_o, r_valid_o);
        check("arst_p", 64'(p), 64'd0);
        check("arst_sp", 64'(sp), 64'd0);
        check("arst_en", 64'(ch_en_o), 64'd0);
        check("arst_rvalid", 64'(r_valid_o), 64'd0);
        // read_enable stays high across an edge while reset is held
        @(negedge clk_in);
        @(negedge clk_in);
        check("arst_abort", 64'(r_valid_o), 64'd0);
        read_enable = 1'b0;
        reset       = 1'b0;
        rd("post_rst_ctrl", 3'd2, 3'd4, 2'd0, 8'h00);
        rd("post_rst_snap", 3'd1, 3'd7, 2'd1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
